// File: rtl/i2c_target_regfile.sv
`default_nettype none
// =====================================================================
// Module   : i2c_target_regfile
// Brief    : I2C target with an auto-incrementing 8-bit register file
// Revision : 1.0
// =====================================================================
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         DEPTH       = 16,
    parameter int         PTR_W       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic             busy,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_reg,
    output logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] host_raddr,
    output logic [7:0]       host_rdata
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_addr      = 3'd1;
    localparam logic [2:0] c_st_addr_ack  = 3'd2;
    localparam logic [2:0] c_st_wr_byte   = 3'd3;
    localparam logic [2:0] c_st_wr_ack    = 3'd4;
    localparam logic [2:0] c_st_rd_byte   = 3'd5;
    localparam logic [2:0] c_st_rd_ack    = 3'd6;
    localparam logic [2:0] c_st_wait_stop = 3'd7;

    logic             r_scl_meta, r_scl_sync, r_scl_hist;
    logic             r_sda_meta, r_sda_sync, r_sda_hist;
    logic [2:0]       r_state;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_shreg;
    logic [PTR_W-1:0] r_ptr;
    logic             r_rw;
    logic             r_first_byte;
    logic             r_ack_phase;
    logic             r_sda_oe;
    logic             r_busy;
    logic             r_wr_strobe;
    logic [PTR_W-1:0] r_wr_reg;
    logic [7:0]       r_wr_data;
    logic [7:0]       r_mem [DEPTH];

    logic       w_start, w_stop, w_scl_rise, w_scl_fall;
    logic [7:0] w_byte;
    logic [7:0] w_mem_ptr;

    // Bus lines idle high, so the synchronizers reset to 1 to avoid phantom edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_hist <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_meta <= scl_i;
            r_scl_sync <= r_scl_meta;
            r_scl_hist <= r_scl_sync;
            r_sda_meta <= sda_i;
            r_sda_sync <= r_sda_meta;
            r_sda_hist <= r_sda_sync;
        end
    end

    assign w_start    = r_scl_sync & r_scl_hist & r_sda_hist & ~r_sda_sync;
    assign w_stop     = r_scl_sync & r_scl_hist & ~r_sda_hist & r_sda_sync;
    assign w_scl_rise = r_scl_sync & ~r_scl_hist;
    assign w_scl_fall = ~r_scl_sync & r_scl_hist;
    assign w_byte     = {r_shreg[6:0], r_sda_sync};
    assign w_mem_ptr  = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_bitcnt     <= 3'd0;
            r_shreg      <= 8'h00;
            r_ptr        <= '0;
            r_rw         <= 1'b0;
            r_first_byte <= 1'b0;
            r_ack_phase  <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_busy       <= 1'b0;
            r_wr_strobe  <= 1'b0;
            r_wr_reg     <= '0;
            r_wr_data    <= 8'h00;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_stop) begin
                r_state  <= c_st_idle;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                r_state  <= c_st_addr;
                r_sda_oe <= 1'b0;
                r_bitcnt <= 3'd0;
            end else begin
                case (r_state)
                    c_st_addr: if (w_scl_rise) begin
                        r_shreg  <= w_byte;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            if (w_byte[7:1] == TARGET_ADDR) begin
                                r_state     <= c_st_addr_ack;
                                r_busy      <= 1'b1;
                                r_rw        <= w_byte[0];
                                r_ack_phase <= 1'b0;
                            end else begin
                                r_state <= c_st_wait_stop;
                            end
                        end
                    end
                    // First fall starts driving ACK, second fall ends the 9th clock.
                    c_st_addr_ack: if (w_scl_fall) begin
                        if (!r_ack_phase) begin
                            r_sda_oe    <= 1'b1;
                            r_ack_phase <= 1'b1;
                        end else begin
                            r_ack_phase <= 1'b0;
                            r_bitcnt    <= 3'd0;
                            if (r_rw) begin
                                r_shreg  <= w_mem_ptr;
                                r_sda_oe <= ~w_mem_ptr[7];
                                r_state  <= c_st_rd_byte;
                            end else begin
                                r_sda_oe     <= 1'b0;
                                r_first_byte <= 1'b1;
                                r_state      <= c_st_wr_byte;
                            end
                        end
                    end
                    c_st_wr_byte: if (w_scl_rise) begin
                        r_shreg  <= w_byte;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            if (r_first_byte) begin
                                r_ptr        <= w_byte[PTR_W-1:0];
                                r_first_byte <= 1'b0;
                            end else begin
                                r_mem[r_ptr] <= w_byte;
                                r_wr_strobe  <= 1'b1;
                                r_wr_reg     <= r_ptr;
                                r_wr_data    <= w_byte;
                                r_ptr        <= r_ptr + PTR_W'(1);
                            end
                            r_state     <= c_st_wr_ack;
                            r_ack_phase <= 1'b0;
                        end
                    end
                    c_st_wr_ack: if (w_scl_fall) begin
                        if (!r_ack_phase) begin
                            r_sda_oe    <= 1'b1;
                            r_ack_phase <= 1'b1;
                        end else begin
                            r_sda_oe    <= 1'b0;
                            r_ack_phase <= 1'b0;
                            r_bitcnt    <= 3'd0;
                            r_state     <= c_st_wr_byte;
                        end
                    end
                    // bitcnt wraps to 0 on the 8th rise; that fall hands SDA back.
                    c_st_rd_byte: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 3'd0) begin
                                r_sda_oe    <= 1'b0;
                                r_ack_phase <= 1'b0;
                                r_state     <= c_st_rd_ack;
                            end else begin
                                r_shreg  <= {r_shreg[6:0], 1'b0};
                                r_sda_oe <= ~r_shreg[6];
                            end
                        end
                    end
                    c_st_rd_ack: begin
                        if (w_scl_rise) begin
                            r_ptr <= r_ptr + PTR_W'(1);
                            if (r_sda_sync) r_state <= c_st_wait_stop;
                            else            r_ack_phase <= 1'b1;
                        end else if (w_scl_fall && r_ack_phase) begin
                            r_ack_phase <= 1'b0;
                            r_shreg     <= w_mem_ptr;
                            r_sda_oe    <= ~w_mem_ptr[7];
                            r_bitcnt    <= 3'd0;
                            r_state     <= c_st_rd_byte;
                        end
                    end
                    c_st_wait_stop: r_sda_oe <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe     = r_sda_oe;
    assign busy       = r_busy;
    assign wr_strobe  = r_wr_strobe;
    assign wr_reg     = r_wr_reg;
    assign wr_data    = r_wr_data;
    assign host_rdata = r_mem[host_raddr];

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
`default_nettype none
// =====================================================================
// Module   : tb_i2c_target_regfile
// Brief    : Bus-level master model with a register-file scoreboard
// Revision : 1.0
// =====================================================================
module tb_i2c_target_regfile;

    localparam int         DEPTH = 16;
    localparam int         PTR_W = 4;
    localparam logic [6:0] ADDR  = 7'h50;

    logic             clk = 1'b0;
    logic             rst;
    logic             scl_m;
    logic             sda_m;
    logic             w_sda_bus;
    logic             sda_oe, busy, wr_strobe;
    logic [PTR_W-1:0] wr_reg;
    logic [7:0]       wr_data;
    logic [PTR_W-1:0] host_raddr;
    logic [7:0]       host_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  m_mem [DEPTH];
    int          m_ptr;
    logic [11:0] exp_wr [$];
    logic [11:0] obs_wr [$];
    logic [7:0]  tx_data [8];

    assign w_sda_bus = sda_m & ~sda_oe;

    i2c_target_regfile #(.TARGET_ADDR(ADDR), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_m),
        .sda_i     (w_sda_bus),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .host_raddr(host_raddr),
        .host_rdata(host_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && wr_strobe) obs_wr.push_back({wr_reg, wr_data});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        wait_clk(2); sda_m = 1'b1;
        wait_clk(6); scl_m = 1'b1;
        wait_clk(8); sda_m = 1'b0;
        wait_clk(8); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(2); sda_m = 1'b0;
        wait_clk(6); scl_m = 1'b1;
        wait_clk(8); sda_m = 1'b1;
        wait_clk(8);
    endtask

    task automatic clock_bit(input logic b, output logic s, output logic oe);
        wait_clk(2); sda_m = b;
        wait_clk(6); scl_m = 1'b1;
        wait_clk(4); s = w_sda_bus; oe = sda_oe;
        wait_clk(4); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack, output logic oe9);
        logic s, oe;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s, oe);
        clock_bit(1'b1, s, oe9);
        ack = ~s;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic s, oe;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s, oe);
            d[i] = s;
        end
        clock_bit(~master_ack, s, oe);
    endtask

    task automatic compare_wr();
        int n;
        wait_clk(4);
        check_eq("wr_count", obs_wr.size(), exp_wr.size());
        n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) check_eq("wr_reg_data", obs_wr[i], exp_wr[i]);
        obs_wr.delete();
        exp_wr.delete();
    endtask

    // tx_data[0] is the register pointer; tx_data[1..n-1] are data bytes.
    task automatic tx_write(input logic [6:0] a, input int n);
        logic ack, oe;
        logic hit;
        hit = (a == ADDR);
        bus_start();
        write_byte({a, 1'b0}, ack, oe);
        check_eq("addr_ack", ack, hit);
        check_eq("busy_addr", busy, hit);
        for (int i = 0; i < n; i++) begin
            write_byte(tx_data[i], ack, oe);
            check_eq("data_ack_oe", oe, hit);
            if (hit) begin
                if (i == 0) begin
                    m_ptr = tx_data[0] % DEPTH;
                end else begin
                    m_mem[m_ptr] = tx_data[i];
                    exp_wr.push_back({4'(m_ptr), tx_data[i]});
                    m_ptr = (m_ptr + 1) % DEPTH;
                end
            end
        end
        bus_stop();
        check_eq("busy_stop", busy, 0);
        compare_wr();
    endtask

    task automatic tx_read(input logic [6:0] a, input logic set_ptr, input logic [7:0] p, input int n);
        logic ack, oe;
        logic hit;
        logic [7:0] d;
        hit = (a == ADDR);
        bus_start();
        if (set_ptr) begin
            write_byte({a, 1'b0}, ack, oe);
            write_byte(p, ack, oe);
            if (hit) m_ptr = p % DEPTH;
            bus_start();
        end
        write_byte({a, 1'b1}, ack, oe);
        check_eq("rd_addr_ack", ack, hit);
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, d);
            if (hit) begin
                check_eq("rd_data", d, m_mem[m_ptr]);
                m_ptr = (m_ptr + 1) % DEPTH;
            end
        end
        check_eq("rd_release", sda_oe, 0);
        bus_stop();
        check_eq("rd_busy_stop", busy, 0);
        compare_wr();
    endtask

    task automatic tx_abort(input logic [7:0] p, input logic [7:0] partial);
        logic ack, oe, s;
        bus_start();
        write_byte({ADDR, 1'b0}, ack, oe);
        write_byte(p, ack, oe);
        m_ptr = p % DEPTH;
        for (int i = 7; i >= 3; i--) clock_bit(partial[i], s, oe);
        bus_stop();
        check_eq("abort_busy", busy, 0);
        compare_wr();
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            host_raddr = PTR_W'(i);
            #1;
            check_eq(tag, host_rdata, m_mem[i]);
        end
    endtask

    initial begin
        logic ack, oe;
        int   op, n;
        logic [6:0] a;
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; host_raddr = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        m_ptr = 0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(1);
        check_eq("rst_sda_oe", sda_oe, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wr_strobe", wr_strobe, 0);
        check_eq("rst_wr_reg", wr_reg, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_mem("rst_mem");

        // Write burst and combined read back
        tx_data[0] = 8'h03; tx_data[1] = 8'hA5; tx_data[2] = 8'h5A;
        tx_write(ADDR, 3);
        check_mem("burst_mem");
        tx_read(ADDR, 1'b1, 8'h03, 2);

        // Address mismatch
        tx_data[0] = 8'h11;
        tx_write(7'h51, 1);
        check_mem("mismatch_mem");

        // Pointer wrap
        tx_data[0] = 8'h0F; tx_data[1] = 8'h11; tx_data[2] = 8'h22;
        tx_write(ADDR, 3);
        check_mem("wrap_mem");

        // Abort mid data byte, then a normal transaction
        tx_abort(8'h06, 8'hC3);
        tx_data[0] = 8'h02; tx_data[1] = 8'h77;
        tx_write(ADDR, 2);

        // Pointer persists across transactions
        tx_data[0] = 8'h07; tx_data[1] = 8'h3C;
        tx_write(ADDR, 2);
        tx_read(ADDR, 1'b0, 8'h00, 1);
        check_mem("persist_mem");

        // Random traffic against the scoreboard
        for (int it = 0; it < 28; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0, 1: begin
                    n = $urandom_range(1, 5);
                    for (int i = 0; i < n; i++) tx_data[i] = 8'($urandom);
                    tx_write(ADDR, n);
                end
                2: tx_read(ADDR, 1'($urandom), 8'($urandom), $urandom_range(1, 4));
                3: begin
                    a = 7'($urandom);
                    if (a == ADDR) a = a ^ 7'h01;
                    tx_data[0] = 8'($urandom); tx_data[1] = 8'($urandom);
                    tx_write(a, 2);
                end
                default: tx_abort(8'($urandom), 8'($urandom));
            endcase
        end
        check_mem("rand_mem");

        // Reset while the target drives a 0 data bit
        tx_data[0] = 8'h09; tx_data[1] = 8'h12;
        tx_write(ADDR, 2);
        bus_start();
        write_byte({ADDR, 1'b0}, ack, oe);
        write_byte(8'h09, ack, oe);
        bus_start();
        write_byte({ADDR, 1'b1}, ack, oe);
        for (int i = 0; i < 20 && !sda_oe; i++) wait_clk(1);
        check_eq("rd_drive_before_rst", sda_oe, 1);
        rst = 1'b1;
        wait_clk(1);
        check_eq("rst_mid_sda_oe", sda_oe, 0);
        check_eq("rst_mid_busy", busy, 0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        m_ptr = 0;
        obs_wr.delete();
        check_mem("rst_mid_mem");
        sda_m = 1'b1; scl_m = 1'b1;
        wait_clk(10);
        tx_data[0] = 8'h01; tx_data[1] = 8'h99;
        tx_write(ADDR, 2);
        tx_read(ADDR, 1'b0, 8'h00, 1);
        check_mem("final_mem");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
